// File: rtl/reg_wb_arbiter.sv
// Two-source arbiter for the single register-file write port (ALU and load writeback).
// Define REG_WB_RR_EN to alternate conflict wins; otherwise the load path always wins conflicts.
module reg_wb_arbiter #(
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [ADDRESS_WIDTH-1:0] alu_addr,
  input  logic [WORD_WIDTH-1:0]    alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0]    mem_data,
  output logic                     mem_ready,
  output logic [ADDRESS_WIDTH-1:0] WA3,
  output logic [WORD_WIDTH-1:0]    WD3,
  output logic                     WEN,
  output logic [15:0]              conflict_cnt
);

  typedef enum logic {
    PRI_MEM = 1'b0,
    PRI_ALU = 1'b1
  } pri_e;

  pri_e                     pri_q, pri_d;
  logic                     conflict;
  logic                     alu_grant, mem_grant;
  logic [ADDRESS_WIDTH-1:0] wa3_q, wa3_d;
  logic [WORD_WIDTH-1:0]    wd3_q, wd3_d;
  logic                     wen_q, wen_d;
  logic [15:0]              cnt_q, cnt_d;

  // Priority state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pri_q <= PRI_MEM;
    end else begin
      pri_q <= pri_d;
    end
  end

  // Priority next state: only a conflict cycle hands priority to the loser
  always_comb begin
    pri_d = pri_q;
`ifdef REG_WB_RR_EN
    if (conflict) begin
      pri_d = (pri_q == PRI_MEM) ? PRI_ALU : PRI_MEM;
    end
`endif
  end

  // Grant outputs; readies are gated by rst_n so nothing is consumed during reset
  always_comb begin
    conflict  = rst_n & alu_valid & mem_valid;
    mem_grant = rst_n & mem_valid & (~alu_valid | (pri_q == PRI_MEM));
    alu_grant = rst_n & alu_valid & (~mem_valid | (pri_q == PRI_ALU));
  end

  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;

  // Writeback datapath: x0 writes are consumed but never enable the port
  always_comb begin
    wa3_d = wa3_q;
    wd3_d = wd3_q;
    wen_d = 1'b0;
    cnt_d = cnt_q;
    if (mem_grant) begin
      wa3_d = mem_addr;
      wd3_d = mem_data;
      wen_d = (mem_addr != '0);
    end else if (alu_grant) begin
      wa3_d = alu_addr;
      wd3_d = alu_data;
      wen_d = (alu_addr != '0);
    end
    if (conflict && (cnt_q != '1)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wa3_q <= '0;
      wd3_q <= '0;
      wen_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      wa3_q <= wa3_d;
      wd3_q <= wd3_d;
      wen_q <= wen_d;
      cnt_q <= cnt_d;
    end
  end

  assign WA3          = wa3_q;
  assign WD3          = wd3_q;
  assign WEN          = wen_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: constant vector table, directed corner sequences,
// and randomized traffic against a cycle-level reference model. Honours REG_WB_RR_EN.
module tb_reg_wb_arbiter;

  localparam int AW = 5;
  localparam int WW = 32;
`ifdef REG_WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, mem_valid;
  logic [AW-1:0] alu_addr, mem_addr;
  logic [WW-1:0] alu_data, mem_data;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] WA3;
  logic [WW-1:0] WD3;
  logic          WEN;
  logic [15:0]   conflict_cnt;

  reg_wb_arbiter #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .WA3(WA3), .WD3(WD3), .WEN(WEN), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: priority owner (0 = load path, 1 = ALU), counter, registered write port
  bit          m_pri;
  int unsigned m_cnt;
  bit          m_wen;
  logic [AW-1:0] m_wa;
  logic [WW-1:0] m_wd;
  bit          e_ar, e_mr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_eval();
    e_ar = 1'b0;
    e_mr = 1'b0;
    if (rst_n) begin
      if (alu_valid && mem_valid) begin
        if (RR && m_pri) e_ar = 1'b1;
        else             e_mr = 1'b1;
      end else begin
        e_ar = alu_valid;
        e_mr = mem_valid;
      end
    end
  endfunction

  function automatic void model_commit();
    if (!rst_n) begin
      m_pri = 1'b0; m_cnt = 0; m_wen = 1'b0; m_wa = '0; m_wd = '0;
      return;
    end
    m_wen = 1'b0;
    if (e_mr) begin m_wa = mem_addr; m_wd = mem_data; m_wen = (mem_addr != 0); end
    if (e_ar) begin m_wa = alu_addr; m_wd = alu_data; m_wen = (alu_addr != 0); end
    if (alu_valid && mem_valid) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (RR) m_pri = e_mr;  // loser takes priority
    end
  endfunction

  task automatic drive(input bit r, input bit av, input logic [AW-1:0] aa, input logic [WW-1:0] ad,
                       input bit mv, input logic [AW-1:0] ma, input logic [WW-1:0] md);
    rst_n = r; alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
  endtask

  // One clock: inputs already driven at edge+1; readies checked at edge+3, outputs at next edge+1
  task automatic tick(input bit chk);
    #2;
    model_eval();
    if (chk) begin
      check("alu_ready", alu_ready, e_ar);
      check("mem_ready", mem_ready, e_mr);
    end
    model_commit();
    @(posedge clk); #1;
    if (chk) begin
      check("WEN", WEN, m_wen);
      if (m_wen) begin
        check("WA3", WA3, m_wa);
        check("WD3", WD3, m_wd);
      end
      check("conflict_cnt", conflict_cnt, m_cnt);
    end
  endtask

  typedef struct {
    logic av; logic [AW-1:0] aa; logic [WW-1:0] ad;
    logic mv; logic [AW-1:0] ma; logic [WW-1:0] md;
    logic ar; logic mr; logic wen; logic [AW-1:0] wa; logic [WW-1:0] wd; logic [15:0] cnt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    bit hold_a, hold_m;
    logic [AW-1:0] exp_wa [4];
    logic          exp_mr [4];

    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 16'd0};
    tbl[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF, 16'd0};
    tbl[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h1234,     1'b0, 1'b1, 1'b0, 5'd0,  32'h1234,     16'd0};
    tbl[3] = '{1'b1, 5'd1,  32'hAAAA,     1'b1, 5'd2,  32'hBBBB,     1'b0, 1'b1, 1'b1, 5'd2,  32'hBBBB,     16'd1};
    tbl[4] = '{1'b1, 5'd1,  32'hAAAA,     1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd1,  32'hAAAA,     16'd1};
    tbl[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 5'd31, 32'hCAFEF00D, 16'd1};
    tbl[6] = '{1'b1, 5'd0,  32'h55,       1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'h55,       16'd1};
    tbl[7] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h55,       16'd1};

    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    @(posedge clk); #1;

    // Reset held with both sources requesting: nothing granted, nothing written
    drive(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    for (int i = 0; i < 3; i++) begin
      #2;
      check("rst_alu_ready", alu_ready, 1'b0);
      check("rst_mem_ready", mem_ready, 1'b0);
      model_eval(); model_commit();
      @(posedge clk); #1;
      check("rst_WEN", WEN, 1'b0);
      check("rst_WA3", WA3, '0);
      check("rst_WD3", WD3, '0);
      check("rst_cnt", conflict_cnt, 16'd0);
    end

    // Constant vector table from the reset state
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].mv, tbl[i].ma, tbl[i].md);
      #2;
      check("tbl_alu_ready", alu_ready, tbl[i].ar);
      check("tbl_mem_ready", mem_ready, tbl[i].mr);
      model_eval(); model_commit();
      @(posedge clk); #1;
      check("tbl_WEN", WEN, tbl[i].wen);
      check("tbl_WA3", WA3, tbl[i].wa);
      check("tbl_WD3", WD3, tbl[i].wd);
      check("tbl_cnt", conflict_cnt, tbl[i].cnt);
    end

    // Continuous conflict from reset: grant order and counter progression
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    tick(1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_mr[i] = RR ? ((i % 2) == 0) : 1'b1;
      exp_wa[i] = exp_mr[i] ? 5'd2 : 5'd1;
    end
    drive(1'b1, 1'b1, 5'd1, 32'h1111, 1'b1, 5'd2, 32'h2222);
    for (int i = 0; i < 4; i++) begin
      #2;
      check("cf_mem_ready", mem_ready, exp_mr[i]);
      check("cf_alu_ready", alu_ready, !exp_mr[i]);
      model_eval(); model_commit();
      @(posedge clk); #1;
      check("cf_WA3", WA3, exp_wa[i]);
      check("cf_WEN", WEN, 1'b1);
      check("cf_cnt", conflict_cnt, 16'(i + 1));
    end

    // Randomized traffic with occasional reset; stalled requesters hold their request
    hold_a = 1'b0; hold_m = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      if (!hold_a) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_addr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
        alu_data  = $urandom;
      end
      if (!hold_m) begin
        mem_valid = ($urandom_range(0, 1) != 0);
        mem_addr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
        mem_data  = $urandom;
      end
      tick(1'b1);
      hold_a = rst_n && alu_valid && !e_ar;
      hold_m = rst_n && mem_valid && !e_mr;
    end

    // Counter saturation boundary
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    tick(1'b1);
    drive(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    for (int i = 0; i < 65534; i++) tick(1'b0);
    check("sat_cnt_fffe", conflict_cnt, 16'hFFFE);
    tick(1'b1);
    check("sat_cnt_ffff", conflict_cnt, 16'hFFFF);
    for (int i = 0; i < 5; i++) tick(1'b1);
    check("sat_cnt_hold", conflict_cnt, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, register address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port alu_valid  input  1  ALU writeback request.
REQ-006 SHALL have port alu_addr  input  ADDRESS_WIDTH  ALU destination register.
REQ-007 SHALL have port alu_data  input  WORD_WIDTH  ALU result.
REQ-008 SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-009 SHALL have port mem_valid  input  1  load writeback request.
REQ-010 SHALL have port mem_addr  input  ADDRESS_WIDTH  load destination register.
REQ-011 SHALL have port mem_data  input  WORD_WIDTH  load data.
REQ-012 SHALL have port mem_ready  output  1  load request accepted this cycle.
REQ-013 SHALL have port WA3  output  ADDRESS_WIDTH  register file write address.
REQ-014 SHALL have port WD3  output  WORD_WIDTH  register file write data.
REQ-015 SHALL have port WEN  output  1  register file write enable.
REQ-016 SHALL have port conflict_cnt  output  16  count of cycles with both requests valid.

Function
REQ-017 SHALL share the single register file write port between two sources; at most one of alu_ready/mem_ready high per cycle.
REQ-018 SHALL treat a transfer as valid&ready in the same cycle; ready is combinational from valid and the priority state.
REQ-019 SHALL never assert a ready whose valid is low.
REQ-020 SHALL grant the sole valid source when only one source is valid.
REQ-021 SHALL, when both are valid, grant the source selected by the priority state (see Configuration); the loser keeps valid high and retries next cycle.
REQ-022 SHALL register the output: one cycle after a transfer, WA3/WD3 equal the accepted addr/data (latency 1).
REQ-023 SHALL assert WEN in that cycle only if the accepted address is non-zero; a write to x0 is accepted (ready high), consumed, and produces WEN=0.
REQ-024 SHALL drive WEN=0 in any cycle following a cycle with no transfer; WA3/WD3 hold their last values.
REQ-025 SHALL not merge same-address requests; both are written in grant order, last grant wins in the register file.
REQ-026 SHALL increment conflict_cnt by 1 per cycle with alu_valid and mem_valid both high, saturating at 0xFFFF.
REQ-027 SHALL sustain one transfer per cycle with no bubbles under continuous valid.
REQ-028 Requesters SHALL hold addr/data stable while valid is high and ready is low; the arbiter does not check this.

Reset
REQ-029 SHALL, while rst_n is low at posedge clk, set WEN=0, WA3=0, WD3=0, conflict_cnt=0, priority state=MEM.
REQ-030 SHALL force alu_ready=0 and mem_ready=0 combinationally while rst_n is low; requests pending at reset are not accepted and produce no write.
REQ-031 SHALL resume arbitration on the first cycle with rst_n high.

Configuration
REQ-032 SHALL use macro REG_WB_RR_EN to select the conflict policy.
REQ-033 With REG_WB_RR_EN defined: priority state is one bit, resets to MEM, toggles after every conflict cycle to the source that lost; non-conflict grants leave it unchanged.
REQ-034 Without REG_WB_RR_EN: mem always wins conflicts; priority state is constant MEM; ALU may starve.

Verification
REQ-035 Reset: rst_n=0 with both valid for 3 cycles -> both readies 0, WEN=0, conflict_cnt=0 throughout.
REQ-036 Single source: alu_valid=1, addr=5, data=0xDEADBEEF, one cycle -> alu_ready=1 that cycle; next cycle WEN=1, WA3=5, WD3=0xDEADBEEF; following cycle WEN=0.
REQ-037 x0 write: mem_valid=1, addr=0, data=0x1234 -> mem_ready=1; next cycle WEN=0.
REQ-038 Conflict, REG_WB_RR_EN defined: both valid continuously, alu addr=1, mem addr=2 -> grants MEM,ALU,MEM,ALU; WA3 sequence 2,1,2,1 with latency 1; conflict_cnt increments each cycle.
REQ-039 Conflict, macro undefined: same stimulus for 4 cycles -> mem_ready=1 every cycle, alu_ready=0, conflict_cnt=4.
REQ-040 Saturation: hold both valid 65540 cycles -> conflict_cnt stops at 0xFFFF.
